// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants for the serial BCD adder: FSM encodings, BCD limits and index sizing.
package bcd_serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  // Digit index needs at least one bit even when only one digit exists.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Host-side request/result bundle for the serial BCD adder; names are from the adder's view.
interface bcd_serial_adder_ctrl_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  i_start;
  logic [4*DIGITS-1:0]   i_a;
  logic [4*DIGITS-1:0]   i_b;
  logic                  i_cin;
  logic [4*DIGITS-1:0]   o_s;
  logic                  o_cout;
  logic                  o_err;
  logic                  o_busy;
  logic                  o_done;

  modport slave (
    input  i_start, i_a, i_b, i_cin,
    output o_s, o_cout, o_err, o_busy, o_done
  );

  modport master (
    output i_start, i_a, i_b, i_cin,
    input  o_s, o_cout, o_err, o_busy, o_done
  );
endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// Combinational single-digit BCD adder with decimal correction and invalid-digit flag.
module bcd_digit_add
  import bcd_serial_adder_ctrl_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_ci,
  output logic [3:0] o_s,
  output logic       o_co,
  output logic       o_err
);

  logic [4:0] w_t;
  logic [4:0] w_tc;
  logic       w_ovf;

  assign w_t   = {1'b0, i_a} + {1'b0, i_b} + {4'b0, i_ci};
  assign w_tc  = w_t + {1'b0, BCD_CORR};
  // Invalid digits take the same path; no saturation.
  assign w_ovf = (w_t > {1'b0, BCD_MAX});
  assign o_s   = w_ovf ? w_tc[3:0] : w_t[3:0];
  assign o_co  = w_ovf;
  assign o_err = (i_a > BCD_MAX) | (i_b > BCD_MAX);

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit BCD adder: one digit adder reused LSD first, carry held in a register.
module bcd_serial_adder_ctrl
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  bcd_serial_adder_ctrl_if.slave       bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IDXW = idx_width(DIGITS);
  localparam logic [IDXW-1:0] LAST = IDXW'(DIGITS - 1);

  logic [1:0]      r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_carry;
  logic [IDXW-1:0] r_idx;
  logic [W-1:0]    r_s;
  logic            r_cout;
  logic            r_err;

  logic [3:0]      w_sum;
  logic            w_co;
  logic            w_derr;

  bcd_digit_add u_digit (
    .i_a   (r_a[3:0]),
    .i_b   (r_b[3:0]),
    .i_ci  (r_carry),
    .o_s   (w_sum),
    .o_co  (w_co),
    .o_err (w_derr)
  );

  // Operands shift right each ADD cycle so the current digit is always at [3:0].
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_a     <= bus.i_a;
            r_b     <= bus.i_b;
            r_carry <= bus.i_cin;
            r_idx   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_state <= ST_ADD;
          end
        end
        ST_ADD: begin
          r_s[4*r_idx +: 4] <= w_sum;
          r_carry <= w_co;
          r_err   <= r_err | w_derr;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
          // Carry-out is captured here so it is already valid alongside DONE.
          if (r_idx == LAST) begin
            r_cout  <= w_co;
            r_state <= ST_FIN;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_s    = r_s;
  assign bus.o_cout = r_cout;
  assign bus.o_err  = r_err;
  assign bus.o_busy = (r_state == ST_ADD) || (r_state == ST_FIN);
  assign bus.o_done = (r_state == ST_FIN);

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for the 4-digit serial BCD adder with hand-computed expected sums.
module tb_bcd_serial_adder_ctrl;

  localparam int unsigned DIGITS = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one operation, scramble inputs afterwards, watch BUSY/DONE and check the result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_s, input logic exp_cout,
                        input logic exp_err, input bit inject);
    int busy_n = 0;
    int done_n = 0;
    int done_at = 0;
    @(negedge clk);
    bus.i_a = a; bus.i_b = b; bus.i_cin = cin; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_a = 16'hFFFF; bus.i_b = 16'hFFFF; bus.i_cin = ~cin;
    for (int c = 1; c <= 20; c++) begin
      if (bus.o_done) begin
        done_n++;
        done_at = c;
        check({tag, " s"},    32'(bus.o_s),    32'(exp_s));
        check({tag, " cout"}, 32'(bus.o_cout), 32'(exp_cout));
        check({tag, " err"},  32'(bus.o_err),  32'(exp_err));
      end
      if (bus.o_busy) busy_n++;
      else break;
      if (inject && c == 2) begin
        bus.i_start = 1'b1; bus.i_a = 16'h9999; bus.i_b = 16'h9999;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(busy_n), 32'd5);
    check({tag, " done count"},  32'(done_n), 32'd1);
    check({tag, " done cycle"},  32'(done_at), 32'd5);
    check({tag, " s held"},      32'(bus.o_s), 32'(exp_s));
  endtask

  initial begin
    int done_n;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_a = '0; bus.i_b = '0; bus.i_cin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset s",    32'(bus.o_s),    32'h0);
    check("reset cout", 32'(bus.o_cout), 32'h0);
    check("reset err",  32'(bus.o_err),  32'h0);
    check("reset busy", 32'(bus.o_busy), 32'h0);
    check("reset done", 32'(bus.o_done), 32'h0);
    rst = 1'b0;

    run_op("basic",     16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    run_op("ripple",    16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("cin9",      16'h0009, 16'h0009, 1'b1, 16'h0019, 1'b0, 1'b0, 1'b0);
    run_op("cin0",      16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op("invalid",   16'h000F, 16'h0000, 1'b0, 16'h0015, 1'b0, 1'b1, 1'b0);
    run_op("errclear",  16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0);
    run_op("max",       16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0);
    run_op("ignorestart", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b1);

    // Abort mid-operation after two digits have been written.
    @(negedge clk);
    bus.i_a = 16'h1234; bus.i_b = 16'h5678; bus.i_cin = 1'b0; bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("partial s", 32'(bus.o_s), 32'h0012);
    #2 rst = 1'b1;
    #1;
    check("abort s",    32'(bus.o_s),    32'h0);
    check("abort busy", 32'(bus.o_busy), 32'h0);
    check("abort done", 32'(bus.o_done), 32'h0);
    check("abort cout", 32'(bus.o_cout), 32'h0);
    check("abort err",  32'(bus.o_err),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy) done_n++;
    end
    check("abort no activity", 32'(done_n), 32'd0);

    run_op("after reset", 16'h4321, 16'h0789, 1'b0, 16'h5110, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
